keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5000, meaning clk cycles per scan tick (>=2).
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 4, meaning consecutive stable ticks required to accept a press or a release (>=1).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port row_in  input  4  keypad rows, active-low, asynchronous to clk.
REQ-006 SHALL have port col_out  output  4  column drive, active-low, exactly one bit low at any time.
REQ-007 SHALL have port key_code  output  4  accepted key, encoded as row*4+col.
REQ-008 SHALL have port key_valid  output  1  key_code holds an unacknowledged key.
REQ-009 SHALL have port key_ack  input  1  consumer acknowledge, one-cycle pulse.
REQ-010 SHALL have port overrun  output  1  sticky flag: a key was accepted while key_valid was 1.

Function
REQ-011 SHALL pass row_in through a 2-flop synchronizer; all row decisions use the synchronized value (2-cycle input latency).
REQ-012 SHALL run a tick counter 0..CLK_DIV-1 and assert an internal tick in the cycle the counter equals CLK_DIV-1, then wrap to 0.
REQ-013 SHALL implement FSM states SCAN, DEBOUNCE, RELEASE; reset state SCAN.
REQ-014 SCAN, on tick: any synchronized row low -> record column index and lowest-index low row, clear the debounce count, go to DEBOUNCE; otherwise advance the column (3 wraps to 0).
REQ-015 col_out SHALL be 4'b1110 for column 0, 4'b1101 for column 1, 4'b1011 for column 2 and 4'b0111 for column 3, updating in the cycle after the advancing tick.
REQ-016 DEBOUNCE, on tick: recorded row still lowest low row -> increment count; count reaching DEBOUNCE_TICKS -> accept key, go to RELEASE; otherwise (row high or different row) -> advance column, go to SCAN, with no key accepted.
REQ-017 The column SHALL be held constant in DEBOUNCE and RELEASE.
REQ-018 RELEASE, on tick: all rows high -> increment count, otherwise clear it; count reaching DEBOUNCE_TICKS -> advance column, go to SCAN.
REQ-019 Accept: in the cycle after the accepting tick, key_code SHALL equal row*4+col and key_valid SHALL be 1, when key_valid was 0 or key_ack is asserted in the accepting cycle.
REQ-020 Accept with key_valid=1 and no key_ack: key_code SHALL be unchanged and overrun SHALL be set to 1.
REQ-021 key_ack with key_valid=1 and no simultaneous accept: key_valid and overrun SHALL clear next cycle, with key_code unchanged.
REQ-022 key_ack with key_valid=0 SHALL have no effect.
REQ-023 Holding a key SHALL produce exactly one accept; auto-repeat is excluded.
REQ-024 Simultaneous keys in one column SHALL resolve to the lowest row; keys in other columns SHALL be ignored until RELEASE completes.

Reset
REQ-025 When rst=1 at a clk edge, next cycle: state=SCAN, column 0, col_out=4'b1110, key_code=4'h0, key_valid=0, overrun=0, tick counter=0, debounce count=0, synchronizer flops=4'b1111.
REQ-026 rst SHALL override key_ack and any in-progress DEBOUNCE or RELEASE; a key held through reset SHALL be re-debounced from SCAN.

Verification (CLK_DIV=4, DEBOUNCE_TICKS=3)
REQ-027 Idle: row_in=4'b1111 for 64 cycles -> col_out cycles 1110,1101,1011,0111,1110 every 4 cycles, and key_valid stays 0.
REQ-028 Single press: row 2 low (row_in=4'b1011) while col 1 driven, held 40 cycles -> key_valid=1 with key_code=4'h9 exactly once, and the column stays 4'b1101 until release plus 3 ticks.
REQ-029 Bounce: row low for 1 tick, then high -> no key_valid, and scanning resumes at column 2.
REQ-030 Overrun: accept 4'h9, release, then press row 0 col 3 without ack -> key_code stays 4'h9 and overrun=1; then key_ack -> key_valid=0 and overrun=0.
REQ-031 Ack and accept in the same cycle -> key_valid stays 1, key_code takes the new value, and overrun stays 0.
REQ-032 rst pulsed mid-DEBOUNCE -> all outputs at their reset values next cycle, and the held key is accepted only after a full new debounce.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, debounced press/release, one-deep key buffer.
// Rows are synchronized; key_code = row*4+col, overrun marks a dropped key.
module keypad_scanner #(
    parameter int CLK_DIV        = 5000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       overrun
);
    localparam int TW = $clog2(CLK_DIV);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        RELEASE
    } state_t;

    state_t        state, state_n;
    logic [3:0]    sync1, sync2;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [1:0]    col, col_n;
    logic [1:0]    rec_row, row_n;
    logic [DW-1:0] db_cnt, cnt_n, db_inc;
    logic          low_any;
    logic [1:0]    low_row;
    logic          accept;

    assign tick    = (tick_cnt == TICK_LAST);
    assign db_inc  = db_cnt + DW'(1);
    assign low_any = ~&sync2;
    assign col_out = ~(4'b0001 << col);

    // Lowest-index active (low) row wins when several keys share a column
    always_comb begin
        low_row = 2'd3;
        if (!sync2[0])      low_row = 2'd0;
        else if (!sync2[1]) low_row = 2'd1;
        else if (!sync2[2]) low_row = 2'd2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 4'hF;
            sync2    <= 4'hF;
            tick_cnt <= '0;
        end else begin
            sync1    <= row_in;
            sync2    <= sync1;
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SCAN;
            col     <= 2'd0;
            rec_row <= 2'd0;
            db_cnt  <= '0;
        end else begin
            state   <= state_n;
            col     <= col_n;
            rec_row <= row_n;
            db_cnt  <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = rec_row;
        cnt_n   = db_cnt;
        accept  = 1'b0;
        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (low_any) begin
                        row_n   = low_row;
                        cnt_n   = '0;
                        state_n = DEBOUNCE;
                    end else begin
                        col_n = col + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (low_any && low_row == rec_row) begin
                        cnt_n = db_inc;
                        if (db_inc == DB_LAST) begin
                            accept  = 1'b1;
                            cnt_n   = '0;
                            state_n = RELEASE;
                        end
                    end else begin
                        col_n   = col + 2'd1;
                        state_n = SCAN;
                    end
                end
                RELEASE: begin
                    cnt_n = low_any ? '0 : db_inc;
                    if (!low_any && db_inc == DB_LAST) begin
                        cnt_n   = '0;
                        col_n   = col + 2'd1;
                        state_n = SCAN;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    // Buffered key survives an unacknowledged accept; that loss is flagged
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (accept && (!key_valid || key_ack)) begin
            key_code  <= {rec_row, col};
            key_valid <= 1'b1;
        end else if (accept) begin
            overrun <= 1'b1;
        end else if (key_ack && key_valid) begin
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus random presses,
// checked every cycle against a tick-level behavioural keypad model.
module tb_keypad_scanner;
    localparam int CD = 4;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_ack = 1'b0;
    logic [3:0] row_in = 4'hF;
    logic [3:0] col_out, key_code;
    logic       key_valid, overrun;

    keypad_scanner #(.CLK_DIV(CD), .DEBOUNCE_TICKS(DB)) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
        .key_code(key_code), .key_valid(key_valid),
        .key_ack(key_ack), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [15:0] keys = '0;
    int rises = 0;
    bit prev_v = 1'b0;

    int m_mode, m_col, m_row, m_cnt, m_cyc;
    logic [3:0] rq[$];
    bit m_valid, m_ovr;
    logic [3:0] m_code;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] r);
        for (int i = 0; i < 4; i++) if (!r[i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0] pad(input int c);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 4; i++) if (keys[i*4+c]) r[i] = 1'b0;
        return r;
    endfunction

    function automatic bit will_accept();
        return (m_cyc % CD) == CD - 1 && m_mode == 1 &&
               lowest(rq[0]) == m_row && m_cnt + 1 == DB;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_col = 0; m_row = 0; m_cnt = 0; m_cyc = 0;
        rq = '{4'hF, 4'hF};
        m_valid = 1'b0; m_ovr = 1'b0; m_code = 4'h0;
    endtask

    // Modes: 0 scanning, 1 confirming a press, 2 waiting for release
    task automatic model_edge();
        logic [3:0] rows;
        bit tk, acc;
        int lo;
        if (rst) begin
            model_reset();
            return;
        end
        rows = rq[0];
        void'(rq.pop_front());
        rq.push_back(row_in);
        tk = (m_cyc % CD) == CD - 1;
        m_cyc++;
        acc = 1'b0;
        lo = lowest(rows);
        if (tk) begin
            if (m_mode == 0) begin
                if (lo >= 0) begin m_row = lo; m_cnt = 0; m_mode = 1; end
                else m_col = (m_col + 1) % 4;
            end else if (m_mode == 1) begin
                if (lo == m_row) begin
                    m_cnt++;
                    if (m_cnt == DB) begin acc = 1'b1; m_cnt = 0; m_mode = 2; end
                end else begin
                    m_col = (m_col + 1) % 4;
                    m_mode = 0;
                end
            end else begin
                m_cnt = (lo < 0) ? m_cnt + 1 : 0;
                if (m_cnt == DB) begin m_cnt = 0; m_col = (m_col + 1) % 4; m_mode = 0; end
            end
        end
        if (acc) begin
            if (!m_valid || key_ack) begin
                m_code = 4'(m_row * 4 + m_col);
                m_valid = 1'b1;
            end else m_ovr = 1'b1;
        end else if (key_ack && m_valid) begin
            m_valid = 1'b0;
            m_ovr = 1'b0;
        end
    endtask

    task automatic step(input bit r, input bit a);
        logic [3:0] ec;
        rst = r;
        key_ack = a;
        row_in = pad(m_col);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        ec = 4'hF;
        ec[m_col] = 1'b0;
        chk("col_out", col_out, ec);
        chk("key_valid", key_valid, m_valid);
        chk("key_code", key_code, m_code);
        chk("overrun", overrun, m_ovr);
        if (key_valid && !prev_v) rises++;
        prev_v = key_valid;
    endtask

    task automatic wait_col(input int c);
        for (int i = 0; i < 64 && m_col == c; i++) step(0, 0);
        for (int i = 0; i < 64 && m_col != c; i++) step(0, 0);
        chk("wait_col", m_col, c);
    endtask

    task automatic wait_scan();
        for (int i = 0; i < 100 && m_mode != 0; i++) step(0, 0);
        chk("wait_scan", m_mode, 0);
    endtask

    task automatic press_9();
        wait_col(1);
        keys = 16'h0200;
        for (int i = 0; i < 100 && !m_valid; i++) step(0, 0);
        chk("p9_valid", key_valid, 1);
        chk("p9_code", key_code, 9);
        keys = '0;
        wait_scan();
    endtask

    initial begin
        bit done, a;
        int k, hold;
        model_reset();
        @(negedge clk);
        repeat (3) step(1, 0);
        chk("rst_col", col_out, 4'b1110);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_ovr", overrun, 0);

        repeat (64) step(0, 0);
        chk("idle_valid", rises, 0);

        rises = 0;
        wait_col(1);
        keys = 16'h0200;
        repeat (40) step(0, 0);
        chk("hold_col", col_out, 4'b1101);
        keys = '0;
        repeat (30) step(0, 0);
        chk("single_once", rises, 1);
        chk("single_code", key_code, 9);
        step(0, 1);
        chk("single_ack", key_valid, 0);
        step(0, 1);

        rises = 0;
        wait_col(1);
        keys = 16'h0200;
        for (int i = 0; i < 20 && m_mode != 1; i++) step(0, 0);
        keys = '0;
        for (int i = 0; i < 20 && m_mode == 1; i++) step(0, 0);
        chk("bounce_col", col_out, 4'b1011);
        repeat (20) step(0, 0);
        chk("bounce_none", rises, 0);

        press_9();
        wait_col(3);
        keys = 16'h0008;
        for (int i = 0; i < 100 && !m_ovr; i++) step(0, 0);
        chk("ovr_flag", overrun, 1);
        chk("ovr_code", key_code, 9);
        keys = '0;
        wait_scan();
        step(0, 1);
        chk("ovr_ack_v", key_valid, 0);
        chk("ovr_ack_o", overrun, 0);

        press_9();
        wait_col(3);
        keys = 16'h0008;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            a = will_accept();
            step(0, a);
            done = a;
        end
        chk("aa_valid", key_valid, 1);
        chk("aa_code", key_code, 3);
        chk("aa_ovr", overrun, 0);
        keys = '0;
        wait_scan();
        step(0, 1);

        wait_col(1);
        keys = 16'h0200;
        for (int i = 0; i < 20 && m_mode != 1; i++) step(0, 0);
        step(1, 0);
        chk("mid_rst_col", col_out, 4'b1110);
        chk("mid_rst_valid", key_valid, 0);
        chk("mid_rst_code", key_code, 0);
        chk("mid_rst_ovr", overrun, 0);
        for (int i = 0; i < 100 && !m_valid; i++) step(0, 0);
        chk("mid_rst_acc", key_code, 9);
        keys = '0;
        wait_scan();
        step(0, 1);

        for (int n = 0; n < 40; n++) begin
            keys = '0;
            k = $urandom_range(15);
            keys[k] = 1'b1;
            if ($urandom_range(2) == 0) begin
                k = $urandom_range(15);
                keys[k] = 1'b1;
            end
            hold = $urandom_range(60, 5);
            repeat (hold) step(0, m_valid && $urandom_range(7) == 0);
            keys = '0;
            hold = $urandom_range(40, 0);
            repeat (hold) step(0, m_valid && $urandom_range(7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
